// File: rtl/fixed_to_float.sv
// fixed_to_float: sequential 32-bit two's-complement fixed point to IEEE-754
// single-precision converter with a START/BUSY/DONE handshake.
// Normalization shifts W left by one bit per clock and decrements the exponent
// on each shift.
// Build option: define FIX2FLT_ROUND_EN for round-to-nearest-even; leave it
// undefined for truncation. Latency is the same in both builds.
//
// state | meaning
// IDLE  | waiting for start; result held on float
// NORM  | shifting W until its leading one sits at bit 30
// PACK  | assembling sign/exponent/mantissa and registering float
module fixed_to_float #(
  parameter int FRAC = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] fixed,
  output logic        busy,
  output logic        done,
  output logic [31:0] float
);

  typedef enum logic [1:0] {IDLE, NORM, PACK} state_t;

  // Bias 127 plus the 30-bit position that bit 30 of W represents.
  localparam logic [7:0] EXP_INIT = 8'(127 + 30 - FRAC);

  state_t      state, state_nxt;
  logic [31:0] w, w_nxt;
  logic [7:0]  e, e_nxt;
  logic        sign, sign_nxt;
  logic        zero, zero_nxt;
  logic        done_nxt;
  logic [31:0] float_nxt;

  logic [22:0] mant;
  logic [7:0]  e_fin;

`ifdef FIX2FLT_ROUND_EN
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] mant_sum;

  // Round to nearest even; a carry out of the mantissa bumps the exponent.
  always_comb begin
    guard    = w[6];
    sticky   = |w[5:0];
    round_up = guard & (sticky | w[7]);
    mant_sum = {1'b0, w[29:7]} + {23'd0, round_up};
    mant     = mant_sum[22:0];
    e_fin    = mant_sum[23] ? e + 8'd1 : e;
  end
`else
  // Truncation: the bits below the mantissa are simply dropped.
  always_comb begin
    mant  = w[29:7];
    e_fin = e;
  end
`endif

  // Next-state and datapath updates; everything holds unless a state acts.
  always_comb begin
    state_nxt = state;
    w_nxt     = w;
    e_nxt     = e;
    sign_nxt  = sign;
    zero_nxt  = zero;
    done_nxt  = 1'b0;
    float_nxt = float;
    case (state)
      IDLE: begin
        if (start) begin
          sign_nxt  = fixed[31];
          // Negating 0x80000000 wraps back to itself, which is the magnitude we want.
          w_nxt     = fixed[31] ? (~fixed + 32'd1) : fixed;
          e_nxt     = EXP_INIT;
          zero_nxt  = 1'b0;
          state_nxt = NORM;
        end
      end
      NORM: begin
        if (w == 32'd0) begin
          zero_nxt  = 1'b1;
          state_nxt = PACK;
        end else if (w[31]) begin
          // Only reachable for the most negative input.
          w_nxt     = {1'b0, w[31:1]};
          e_nxt     = e + 8'd1;
          state_nxt = PACK;
        end else if (w[30]) begin
          state_nxt = PACK;
        end else begin
          w_nxt = {w[30:0], 1'b0};
          e_nxt = e - 8'd1;
        end
      end
      PACK: begin
        float_nxt = zero ? 32'd0 : {sign, e_fin, mant};
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and output registers; reset discards any conversion in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      w     <= 32'd0;
      e     <= 8'd0;
      sign  <= 1'b0;
      zero  <= 1'b0;
      done  <= 1'b0;
      float <= 32'd0;
    end else begin
      state <= state_nxt;
      w     <= w_nxt;
      e     <= e_nxt;
      sign  <= sign_nxt;
      zero  <= zero_nxt;
      done  <= done_nxt;
      float <= float_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fixed_to_float.sv
// Testbench for fixed_to_float (FRAC=30): scoreboard of expected results and
// latencies, popped and compared whenever DONE is seen.
module tb_fixed_to_float;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] fixed;
  logic        busy;
  logic        done;
  logic [31:0] float;

  typedef struct {
    logic [31:0] exp_float;
    int          acc_cyc;
    int          exp_lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  fixed_to_float #(.FRAC(30)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .fixed (fixed),
    .busy  (busy),
    .done  (done),
    .float (float)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: every DONE pops one expectation and checks value and latency.
  always @(negedge clk) begin
    if (rst && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("float", float, x.exp_float);
        chk("latency", 32'(cyc - x.acc_cyc), 32'(x.exp_lat));
        chk("busy_in_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  // Issue one conversion at the first negedge with busy low (may be a DONE cycle).
  task automatic run(input logic [31:0] val, input logic [31:0] exp_f, input int lat);
    int guard_cnt;
    exp_t x;
    guard_cnt = 0;
    @(negedge clk);
    while (busy && guard_cnt < 100) begin
      @(negedge clk);
      guard_cnt++;
    end
    if (busy) chk("wait_idle_timeout", 32'd1, 32'd0);
    start = 1'b1;
    fixed = val;
    x.exp_float = exp_f;
    x.acc_cyc   = cyc + 1;
    x.exp_lat   = lat;
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
    fixed = 32'hDEADBEEF;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] r_c0, r_ff;
    start = 1'b0;
    fixed = 32'd0;
    rst   = 1'b0;
`ifdef FIX2FLT_ROUND_EN
    r_c0 = 32'h3F800002;
    r_ff = 32'h40000000;
`else
    r_c0 = 32'h3F800001;
    r_ff = 32'h3FFFFFFF;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_float", float, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_float", float, 32'd0);

    run(32'h40000000, 32'h3F800000, 2);
    run(32'hC0000000, 32'hBF800000, 2);
    run(32'h20000000, 32'h3F000000, 3);
    run(32'h80000000, 32'hC0000000, 2);
    run(32'h00000000, 32'h00000000, 2);
    run(32'h400000C0, r_c0, 2);
    run(32'h40000040, 32'h3F800000, 2);
    run(32'h7FFFFFFF, r_ff, 2);
    run(32'hF0000000, 32'hBE800000, 4);
    drain();

    // Longest conversion with ignored start pulses while busy.
    run(32'h00000001, 32'h30800000, 32);
    for (int i = 0; i < 28; i++) begin
      chk("busy_long", {31'd0, busy}, 32'd1);
      if (i % 5 == 2) begin
        start = 1'b1;
        fixed = 32'h40000000;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    // Back-to-back: this request lands in the DONE cycle of the one above.
    run(32'h20000000, 32'h3F000000, 3);
    chk("b2b_accepted_in_done", {31'd0, busy}, 32'd1);
    drain();

    // Reset mid-NORM discards the conversion.
    run(32'h00000001, 32'h30800000, 32);
    repeat (8) @(negedge clk);
    chk("busy_pre_rst", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    chk("rst_mid_float", float, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_float", float, 32'd0);
    run(32'h40000000, 32'h3F800000, 2);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
